// File: rtl/blockram_stream_reader_if.sv
// Command, RAM read-port and output-stream signals of blockram_stream_reader.
// The master modport is the reader itself; the slave modport is its environment.
interface blockram_stream_reader_if #(
   parameter int WIDTH   = 64,
   parameter int NUM_SET = 64,
   parameter int PTR     = $clog2(NUM_SET)
);
   // Handshake: a command or beat transfers on a posedge where valid and ready are
   // both 1. The source holds valid and payload stable until then; ready may toggle.
   logic             cmd_valid_in;
   logic             cmd_ready_out;
   logic [PTR-1:0]   cmd_start_addr_in;
   logic [PTR:0]     cmd_length_in;

   logic             ram_read_en_out;
   logic [PTR-1:0]   ram_read_addr_out;
   logic [WIDTH-1:0] ram_read_data_in;
   logic             ram_read_valid_in;

   logic             data_valid_out;
   logic             data_ready_in;
   logic [WIDTH-1:0] data_out;
   logic             data_miss_out;
   logic             data_last_out;
   logic             busy_out;
   logic             done_out;

   modport master (
      input  cmd_valid_in, cmd_start_addr_in, cmd_length_in,
      input  ram_read_data_in, ram_read_valid_in, data_ready_in,
      output cmd_ready_out, ram_read_en_out, ram_read_addr_out,
      output data_valid_out, data_out, data_miss_out, data_last_out, busy_out, done_out
   );

   modport slave (
      output cmd_valid_in, cmd_start_addr_in, cmd_length_in,
      output ram_read_data_in, ram_read_valid_in, data_ready_in,
      input  cmd_ready_out, ram_read_en_out, ram_read_addr_out,
      input  data_valid_out, data_out, data_miss_out, data_last_out, busy_out, done_out
   );
endinterface

// File: rtl/blockram_stream_reader.sv
// Streams {start, length} ranges out of a 1-cycle-latency block RAM through a 2-entry skid buffer.
// Optional BLOCKRAM_READER_ABORT_ON_INVALID_EN: stop at the first never-written entry, flag error_out.
module blockram_stream_reader #(
   parameter int SINGLE_ENTRY_WIDTH_IN_BITS = 64,
   parameter int NUM_SET                    = 64,
   parameter int SET_PTR_WIDTH_IN_BITS      = $clog2(NUM_SET)
) (
   input  logic                       clk_in,
   input  logic                       reset_in,
   blockram_stream_reader_if.master   bus,
`ifdef BLOCKRAM_READER_ABORT_ON_INVALID_EN
   output logic                       error_out,
`endif
   output logic [1:0]                 state_dbg_out
);
   localparam int W = SINGLE_ENTRY_WIDTH_IN_BITS;
   localparam int P = SET_PTR_WIDTH_IN_BITS;
   localparam logic [P:0] LEFT_ONE = {{P{1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [P-1:0]      addr_q, addr_d;
   logic [P:0]        issue_left_q, issue_left_d;
   logic              inflight_q, inflight_d;
   logic              inflight_last_q, inflight_last_d;
   logic [1:0][W-1:0] skid_data_q, skid_data_d;
   logic [1:0]        skid_miss_q, skid_miss_d;
   logic [1:0]        skid_last_q, skid_last_d;
   logic              rd_ptr_q, rd_ptr_d;
   logic              wr_ptr_q, wr_ptr_d;
   logic [1:0]        count_q, count_d;

   logic       accept, pop, push, miss, stop, issue, head_last;
   logic [2:0] occ;

   assign accept    = (state_q == S_IDLE) && bus.cmd_valid_in;
   assign pop       = (count_q != 2'd0) && bus.data_ready_in;
   assign push      = inflight_q;
   assign miss      = !bus.ram_read_valid_in;
   assign head_last = skid_last_q[rd_ptr_q];
`ifdef BLOCKRAM_READER_ABORT_ON_INVALID_EN
   assign stop      = push && miss;
`else
   assign stop      = 1'b0;
`endif
   // Occupancy the buffer will see next cycle if nothing new is issued now.
   assign occ       = {1'b0, count_q} + {2'b0, inflight_q} - {2'b0, pop};
   assign issue     = (state_q == S_ISSUE) && !stop && (occ < 3'd2);
   assign count_d   = count_q + {1'b0, push} - {1'b0, pop};

   always_comb begin
      state_d         = state_q;
      addr_d          = addr_q;
      issue_left_d    = issue_left_q;
      inflight_d      = 1'b0;
      inflight_last_d = 1'b0;
      skid_data_d     = skid_data_q;
      skid_miss_d     = skid_miss_q;
      skid_last_d     = skid_last_q;
      rd_ptr_d        = rd_ptr_q;
      wr_ptr_d        = wr_ptr_q;

      if (pop) rd_ptr_d = ~rd_ptr_q;
      if (push) begin
         skid_data_d[wr_ptr_q] = bus.ram_read_data_in;
         skid_miss_d[wr_ptr_q] = miss;
         skid_last_d[wr_ptr_q] = inflight_last_q || stop;
         wr_ptr_d              = ~wr_ptr_q;
      end
      if (issue) begin
         addr_d          = addr_q + {{(P-1){1'b0}}, 1'b1};
         issue_left_d    = issue_left_q - LEFT_ONE;
         inflight_d      = 1'b1;
         inflight_last_d = (issue_left_q == LEFT_ONE);
      end

      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               addr_d       = bus.cmd_start_addr_in;
               issue_left_d = bus.cmd_length_in;
               state_d      = (bus.cmd_length_in == '0) ? S_DONE : S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (stop || (issue && issue_left_q == LEFT_ONE)) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            if (pop && head_last) state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (!reset_in) begin
         state_q         <= S_IDLE;
         addr_q          <= '0;
         issue_left_q    <= '0;
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
         skid_data_q     <= '0;
         skid_miss_q     <= '0;
         skid_last_q     <= '0;
         rd_ptr_q        <= 1'b0;
         wr_ptr_q        <= 1'b0;
         count_q         <= '0;
      end else begin
         state_q         <= state_d;
         addr_q          <= addr_d;
         issue_left_q    <= issue_left_d;
         inflight_q      <= inflight_d;
         inflight_last_q <= inflight_last_d;
         skid_data_q     <= skid_data_d;
         skid_miss_q     <= skid_miss_d;
         skid_last_q     <= skid_last_d;
         rd_ptr_q        <= rd_ptr_d;
         wr_ptr_q        <= wr_ptr_d;
         count_q         <= count_d;
      end
   end

`ifdef BLOCKRAM_READER_ABORT_ON_INVALID_EN
   logic abort_q, abort_d;

   always_comb begin
      abort_d = abort_q;
      if (accept)    abort_d = 1'b0;
      else if (stop) abort_d = 1'b1;
   end

   always_ff @(posedge clk_in) begin
      if (!reset_in) abort_q <= 1'b0;
      else           abort_q <= abort_d;
   end

   assign error_out = (state_q == S_DONE) && abort_q;
`endif

   assign bus.cmd_ready_out     = (state_q == S_IDLE);
   assign bus.busy_out          = (state_q != S_IDLE);
   assign bus.done_out          = (state_q == S_DONE);
   assign bus.ram_read_en_out   = issue;
   assign bus.ram_read_addr_out = addr_q;
   assign bus.data_valid_out    = (count_q != 2'd0);
   assign bus.data_out          = skid_data_q[rd_ptr_q];
   assign bus.data_miss_out     = (count_q != 2'd0) && skid_miss_q[rd_ptr_q];
   assign bus.data_last_out     = (count_q != 2'd0) && head_last;
   assign state_dbg_out         = state_q;
endmodule
